// File: rtl/pmem_arbiter_pkg.sv
// Shared types and default widths for the I/D physical-memory port arbiter.
package pmem_arb_types;

    localparam int ADDR_W_DEF   = 32;
    localparam int LINE_W_DEF   = 256;
    localparam int OFFSET_W_DEF = 5;
    localparam int CNT_W_DEF    = 32;

    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, DONE} arb_state_t;
    typedef enum logic {GRANT_I, GRANT_D} grant_t;

endpackage

// File: rtl/pmem_arbiter_sat_counter.sv
// Free-running event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
        return (&v) ? v : v + WIDTH'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (rst)
            count <= '0;
        else if (inc)
            count <= sat_inc(count);
    end

endmodule

// File: rtl/pmem_arbiter.sv
// Round-robin arbiter sharing one line-wide memory port between I-cache and D-cache,
// with per-requester wait-cycle counters.
module pmem_arbiter
    import pmem_arb_types::*;
#(
    parameter int ADDR_WIDTH  = ADDR_W_DEF,
    parameter int LINE_WIDTH  = LINE_W_DEF,
    parameter int OFFSET_BITS = OFFSET_W_DEF,
    parameter int CNT_WIDTH   = CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_pmem_read,
    input  logic [ADDR_WIDTH-1:0] i_pmem_address,
    output logic [LINE_WIDTH-1:0] i_pmem_rdata,
    output logic                  i_pmem_resp,
    input  logic                  d_pmem_read,
    input  logic                  d_pmem_write,
    input  logic [ADDR_WIDTH-1:0] d_pmem_address,
    input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
    output logic [LINE_WIDTH-1:0] d_pmem_rdata,
    output logic                  d_pmem_resp,
    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic [LINE_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp,
    output logic [CNT_WIDTH-1:0]  i_wait_cnt,
    output logic [CNT_WIDTH-1:0]  d_wait_cnt
);

    arb_state_t            state, state_nxt;
    grant_t                last_grant, grant_sel;
    logic                  op_write_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LINE_WIDTH-1:0] wdata_q;
    logic                  i_req, d_req, grant_now;

    function automatic logic [ADDR_WIDTH-1:0] line_align(input logic [ADDR_WIDTH-1:0] a);
        return {a[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
    endfunction

    assign i_req     = i_pmem_read;
    assign d_req     = d_pmem_read | d_pmem_write;
    assign grant_now = (state == IDLE) && (i_req || d_req);

    // On contention the requester that was not served last wins.
    always_comb begin
        grant_sel = GRANT_D;
        if (i_req && d_req)
            grant_sel = (last_grant == GRANT_D) ? GRANT_I : GRANT_D;
        else if (i_req)
            grant_sel = GRANT_I;
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:             if (i_req || d_req)
                                  state_nxt = (grant_sel == GRANT_I) ? SERVE_I : SERVE_D;
            SERVE_I, SERVE_D: if (pmem_resp) state_nxt = DONE;
            DONE:             state_nxt = IDLE;
            default:          state_nxt = IDLE;
        endcase
    end

    // Request pins are captured once at grant; later changes on them are ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= GRANT_D;
            op_write_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            if (grant_now) begin
                addr_q     <= line_align((grant_sel == GRANT_I) ? i_pmem_address : d_pmem_address);
                op_write_q <= (grant_sel == GRANT_D) && d_pmem_write;
                if ((grant_sel == GRANT_D) && d_pmem_write)
                    wdata_q <= d_pmem_wdata;
            end
            if ((state == SERVE_I || state == SERVE_D) && pmem_resp)
                last_grant <= (state == SERVE_I) ? GRANT_I : GRANT_D;
        end
    end

    always_comb begin
        pmem_read   = 1'b0;
        pmem_write  = 1'b0;
        i_pmem_resp = 1'b0;
        d_pmem_resp = 1'b0;
        unique case (state)
            SERVE_I: begin
                pmem_read   = ~op_write_q;
                pmem_write  = op_write_q;
                i_pmem_resp = pmem_resp;
            end
            SERVE_D: begin
                pmem_read   = ~op_write_q;
                pmem_write  = op_write_q;
                d_pmem_resp = pmem_resp;
            end
            default: ;
        endcase
    end

    assign pmem_address = addr_q;
    assign pmem_wdata   = wdata_q;
    assign i_pmem_rdata = pmem_rdata;
    assign d_pmem_rdata = pmem_rdata;

    sat_counter #(.WIDTH(CNT_WIDTH)) u_i_wait (
        .clk   (clk),
        .rst   (rst),
        .inc   (i_req && (state != SERVE_I)),
        .count (i_wait_cnt)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_d_wait (
        .clk   (clk),
        .rst   (rst),
        .inc   (d_req && (state != SERVE_D)),
        .count (d_wait_cnt)
    );

endmodule

// File: tb/tb_pmem_arbiter.sv
// Randomized scoreboard bench for pmem_arbiter with a transaction-level arbitration model.
`timescale 1ns/1ps
module tb_pmem_arbiter;

    localparam int AW = 32, LW = 256, OB = 5, CW = 6, CMAX = 63;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          i_pmem_read, i_pmem_resp, d_pmem_read, d_pmem_write, d_pmem_resp;
    logic [AW-1:0] i_pmem_address, d_pmem_address, pmem_address;
    logic [LW-1:0] i_pmem_rdata, d_pmem_rdata, d_pmem_wdata, pmem_wdata, pmem_rdata;
    logic          pmem_read, pmem_write, pmem_resp;
    logic [CW-1:0] i_wait_cnt, d_wait_cnt;

    pmem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .OFFSET_BITS(OB), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst),
        .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
        .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
        .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
        .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
        .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
        .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
        .i_wait_cnt(i_wait_cnt), .d_wait_cnt(d_wait_cnt)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic          rd;
        logic          wr;
        logic [LW-1:0] wdata;
        int            gap;
        bit            scramble;
    } job_t;

    job_t i_jobs[$], d_jobs[$];
    job_t exp_i[$], exp_d[$];
    int   grant_log[$];
    int   total = 0, bad = 0;
    bit   i_busy = 0, d_busy = 0, d_abort = 0, spur = 0;
    int   fixed_lat = -1;
    logic [LW-1:0] mem_data = '0;

    // Reference model: 0 = I, 1 = D
    bit   m_busy = 0, m_gap = 0;
    int   m_who = 1, m_last = 1, m_icnt = 0, m_dcnt = 0;
    job_t m_cur;

    task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic job_t mk_job(input logic [AW-1:0] a, input logic rd, input logic wr,
                                    input logic [LW-1:0] wd, input int gap, input bit scr);
        job_t j;
        j.addr = a; j.rd = rd; j.wr = wr; j.wdata = wd; j.gap = gap; j.scramble = scr;
        return j;
    endfunction

    function automatic logic [LW-1:0] rnd_line();
        logic [LW-1:0] v;
        for (int k = 0; k < LW / 32; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic set_pins(input bit is_d, input job_t j, input bit on);
        if (is_d) begin
            d_pmem_read = on & j.rd; d_pmem_write = on & j.wr;
            d_pmem_address = j.addr; d_pmem_wdata = j.wdata;
        end else begin
            i_pmem_read = on; i_pmem_address = j.addr;
        end
    endtask

    task automatic requester(input bit is_d);
        job_t j, j2;
        int   n;
        bit   got;
        forever begin
            @(posedge clk); #1;
            if (is_d ? (d_jobs.size() == 0) : (i_jobs.size() == 0)) continue;
            if (is_d) begin j = d_jobs.pop_front(); d_busy = 1; end
            else      begin j = i_jobs.pop_front(); i_busy = 1; end
            for (int k = 0; k < j.gap; k++) begin @(posedge clk); #1; end
            set_pins(is_d, j, 1'b1);
            if (is_d) exp_d.push_back(j); else exp_i.push_back(j);
            got = 0; n = 0;
            while (!got && n < 400) begin
                @(negedge clk);
                n++;
                got = is_d ? (d_pmem_resp || d_abort) : i_pmem_resp;
                if (j.scramble && n >= 2 && !got) begin
                    j2 = j; j2.addr = $urandom; j2.wdata = rnd_line();
                    set_pins(is_d, j2, 1'b1);
                end
            end
            if (!got) begin
                total++; bad++;
                $display("FAIL resp_timeout_%s: no resp after %0d cycles, required one", is_d ? "d" : "i", n);
            end
            @(posedge clk); #1;
            set_pins(is_d, j, 1'b0);
            if (is_d) d_busy = 0; else i_busy = 0;
        end
    endtask

    initial requester(1'b0);
    initial requester(1'b1);

    // Memory: answers each strobe after a latency, or once on demand via spur.
    initial begin : memory
        int  cnt, lat;
        bit  fire;
        cnt = 0; lat = 0;
        forever begin
            @(negedge clk);
            fire = 0;
            if (rst) cnt = 0;
            else if ((pmem_read || pmem_write) && !pmem_resp) begin
                if (cnt == 0) lat = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 6));
                if (cnt >= lat) begin fire = 1; cnt = 0; end
                else cnt++;
            end
            if (spur) begin fire = 1; spur = 0; end
            @(posedge clk); #1;
            pmem_resp = fire;
            if (fire) begin pmem_rdata = rnd_line(); mem_data = pmem_rdata; end
        end
    end

    // Monitor: compares every cycle against the model, then advances the model.
    initial begin : monitor
        bit ir, dr, exp_ir, exp_dr;
        forever begin
            @(negedge clk);
            check("pmem_read", pmem_read, m_busy && !m_cur.wr);
            check("pmem_write", pmem_write, m_busy && m_cur.wr);
            exp_ir = m_busy && (m_who == 0) && pmem_resp;
            exp_dr = m_busy && (m_who == 1) && pmem_resp;
            check("i_pmem_resp", i_pmem_resp, exp_ir);
            check("d_pmem_resp", d_pmem_resp, exp_dr);
            if (m_busy) begin
                check("pmem_address", pmem_address, {m_cur.addr[AW-1:OB], {OB{1'b0}}});
                if (m_cur.wr) check("pmem_wdata", pmem_wdata, m_cur.wdata);
            end
            if (exp_ir) check("i_pmem_rdata", i_pmem_rdata, mem_data);
            if (exp_dr) check("d_pmem_rdata", d_pmem_rdata, mem_data);
            check("i_wait_cnt", i_wait_cnt, m_icnt);
            check("d_wait_cnt", d_wait_cnt, m_dcnt);

            ir = i_pmem_read;
            dr = d_pmem_read || d_pmem_write;
            if (rst) begin
                m_busy = 0; m_gap = 0; m_last = 1; m_icnt = 0; m_dcnt = 0;
            end else begin
                if (ir && !(m_busy && m_who == 0)) m_icnt = (m_icnt < CMAX) ? m_icnt + 1 : CMAX;
                if (dr && !(m_busy && m_who == 1)) m_dcnt = (m_dcnt < CMAX) ? m_dcnt + 1 : CMAX;
                if (m_busy) begin
                    if (pmem_resp) begin m_busy = 0; m_gap = 1; m_last = m_who; end
                end else if (m_gap) begin
                    m_gap = 0;
                end else if (ir || dr) begin
                    m_who = (ir && dr) ? ((m_last == 1) ? 0 : 1) : (ir ? 0 : 1);
                    grant_log.push_back(m_who);
                    m_busy = 1;
                    if (m_who == 0 ? exp_i.size() == 0 : exp_d.size() == 0) begin
                        total++; bad++;
                        $display("FAIL grant_%0d: got grant with no issued request, required none", m_who);
                        m_busy = 0;
                    end else if (m_who == 0) m_cur = exp_i.pop_front();
                    else m_cur = exp_d.pop_front();
                end
            end
        end
    end

    task automatic wait_quiet(input string name);
        int n = 0;
        while ((i_jobs.size() != 0 || d_jobs.size() != 0 || i_busy || d_busy || m_busy || m_gap)
               && n < 3000) begin
            @(negedge clk); n++;
        end
        total++;
        if (n >= 3000) begin
            bad++;
            $display("FAIL %s: still busy after %0d cycles, required idle", name, n);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic check_order(input string name, input int exp_q[$]);
        check({name, "_len"}, grant_log.size(), exp_q.size());
        for (int k = 0; k < exp_q.size() && k < grant_log.size(); k++)
            check($sformatf("%s_%0d", name, k), grant_log[k], exp_q[k]);
    endtask

    initial begin : watchdog
        #800000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        job_t j;
        int   n;
        rst = 1; i_pmem_read = 0; i_pmem_address = '0;
        d_pmem_read = 0; d_pmem_write = 0; d_pmem_address = '0; d_pmem_wdata = '0;
        pmem_resp = 0; pmem_rdata = '0;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        check("rst_pmem_read", pmem_read, 0);
        check("rst_pmem_write", pmem_write, 0);
        check("rst_pmem_address", pmem_address, 0);
        check("rst_pmem_wdata", pmem_wdata, 0);
        check("rst_i_resp", i_pmem_resp, 0);
        check("rst_d_resp", d_pmem_resp, 0);
        check("rst_i_cnt", i_wait_cnt, 0);
        check("rst_d_cnt", d_wait_cnt, 0);

        // I-only read
        fixed_lat = 4;
        i_jobs.push_back(mk_job(32'h0000_1234, 1, 0, '0, 0, 0));
        wait_quiet("i_only");
        check("i_only_cnt", i_wait_cnt, 1);

        // D writeback with request pins scrambled after grant
        fixed_lat = 2;
        d_jobs.push_back(mk_job(32'h8000_0040, 0, 1, {32{8'hA5}}, 0, 1));
        wait_quiet("d_write");

        // Simultaneous requests, twice
        fixed_lat = -1;
        grant_log.delete();
        @(negedge clk);
        i_jobs.push_back(mk_job($urandom, 1, 0, '0, 0, 0));
        d_jobs.push_back(mk_job($urandom, 1, 0, '0, 0, 0));
        wait_quiet("simul_a");
        i_jobs.push_back(mk_job($urandom, 1, 0, '0, 0, 0));
        d_jobs.push_back(mk_job($urandom, 0, 1, rnd_line(), 0, 0));
        wait_quiet("simul_b");
        check_order("simul_order", '{0, 1, 0, 1});

        // Continuous contention alternates
        grant_log.delete();
        @(negedge clk);
        for (int k = 0; k < 3; k++) i_jobs.push_back(mk_job($urandom, 1, 0, '0, 0, 0));
        for (int k = 0; k < 2; k++) d_jobs.push_back(mk_job($urandom, 1, 0, '0, 0, 0));
        wait_quiet("starve");
        check_order("starve_order", '{0, 1, 0, 1, 0});

        // Read and write both high is a write
        d_jobs.push_back(mk_job(32'h0000_0abc, 1, 1, rnd_line(), 0, 0));
        wait_quiet("rd_wr_both");

        // Long I transaction makes D's counter saturate
        fixed_lat = 70;
        grant_log.delete();
        @(negedge clk);
        i_jobs.push_back(mk_job($urandom, 1, 0, '0, 0, 0));
        d_jobs.push_back(mk_job($urandom, 0, 1, rnd_line(), 0, 0));
        wait_quiet("saturate");
        check_order("sat_order", '{0, 1});
        check("sat_d_cnt", d_wait_cnt, CMAX);

        // Randomized traffic
        fixed_lat = -1;
        for (int r = 0; r < 40; r++) begin
            @(negedge clk);
            if ($urandom_range(0, 1)) i_jobs.push_back(mk_job($urandom, 1, 0, '0, $urandom_range(0, 3), 0));
            if ($urandom_range(0, 1)) begin
                j = mk_job($urandom, 0, 0, rnd_line(), $urandom_range(0, 3), 0);
                case ($urandom_range(0, 2))
                    0: j.rd = 1;
                    1: j.wr = 1;
                    default: begin j.rd = 1; j.wr = 1; end
                endcase
                d_jobs.push_back(j);
            end
            repeat ($urandom_range(0, 8)) @(negedge clk);
        end
        wait_quiet("random");

        // Reset during a D transaction; a late memory resp must not reach D
        fixed_lat = 20;
        d_jobs.push_back(mk_job(32'h0000_4460, 0, 1, rnd_line(), 0, 0));
        n = 0;
        while (!m_busy && n < 50) begin @(negedge clk); n++; end
        check("rst_mid_granted", m_busy, 1);
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1; d_abort = 1;
        @(posedge clk); #1;
        rst = 0; spur = 1;
        @(negedge clk);
        check("rst_mid_read", pmem_read, 0);
        check("rst_mid_write", pmem_write, 0);
        check("rst_mid_address", pmem_address, 0);
        check("rst_mid_wdata", pmem_wdata, 0);
        check("rst_mid_d_cnt", d_wait_cnt, 0);
        check("rst_mid_i_cnt", i_wait_cnt, 0);
        @(negedge clk);
        check("late_resp_d", d_pmem_resp, 0);
        check("late_resp_i", i_pmem_resp, 0);
        d_abort = 0;
        fixed_lat = -1;
        wait_quiet("after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
